// File: rtl/multicycle_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : multicycle_controller                                      |
// | Description : Multi-cycle main control FSM for the RV32 core. Sequences  |
// |               each instruction through fetch / decode / execute /        |
// |               memory / writeback, waits on a ready handshake to the      |
// |               shared instruction/data memory, traps on an illegal        |
// |               opcode or on a memory timeout, and drives the datapath     |
// |               mux selects and write strobes.                             |
// | Option      : CTRL_JUMP_EN - when defined, JAL (1101111) is executed     |
// |               through the JAL state; otherwise it traps as illegal.      |
// | Ports       : clk_i, rst_ni (async, active low), opcode_i[6:0],          |
// |               mem_ready_i  -> mem_req_o, mem_we_o, adr_src_o, ir_we_o,   |
// |               pc_we_o, alu_src_a_o[1:0], alu_src_b_o[1:0],               |
// |               alu_op_o[ALU_OP_W-1:0], result_src_o[1:0], reg_write_o,    |
// |               branch_o, retire_o, illegal_o, mem_err_o,                  |
// |               state_o[STATE_W-1:0]                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module multicycle_controller #(
  parameter int ALU_OP_W    = 2,
  parameter int MEM_TIMEOUT = 16,
  parameter int STATE_W     = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [6:0]          opcode_i,
  input  logic                mem_ready_i,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic                adr_src_o,
  output logic                ir_we_o,
  output logic                pc_we_o,
  output logic [1:0]          alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic [1:0]          result_src_o,
  output logic                reg_write_o,
  output logic                branch_o,
  output logic                retire_o,
  output logic                illegal_o,
  output logic                mem_err_o,
  output logic [STATE_W-1:0]  state_o
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_ALU_WB  = 4'd8,
    S_BRANCH  = 4'd9,
    S_JAL     = 4'd10,
    S_TRAP    = 4'd15
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Counter only has to reach MEM_TIMEOUT-1.
  localparam int CNT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int TO_LIMIT = (MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             mem_err_q, mem_err_d;

  logic             waiting;
  logic             cnt_at_limit;
  logic             timeout_hit;
  logic             entering_wait;

  // States that hold a memory request open and wait on mem_ready_i.
  assign waiting = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign cnt_at_limit = (cnt_q == CNT_W'(TO_LIMIT));
  // A ready on the final allowed cycle completes normally.
  assign timeout_hit = (MEM_TIMEOUT != 0) && waiting && !mem_ready_i && cnt_at_limit;

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    mem_err_d = mem_err_q;

    case (state_q)
      S_FETCH:   if (mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode_i)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
`ifdef CTRL_JUMP_EN
          OP_JAL:            state_d = S_JAL;
`endif
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADR: state_d = (opcode_i == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  if (mem_ready_i) state_d = S_MEM_WB;
      S_MEM_WB:  state_d = S_FETCH;
      S_MEM_WR:  if (mem_ready_i) state_d = S_FETCH;
      S_EXEC_R:  state_d = S_ALU_WB;
      S_EXEC_I:  state_d = S_ALU_WB;
      S_ALU_WB:  state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
`ifdef CTRL_JUMP_EN
      S_JAL:     state_d = S_ALU_WB;
`endif
      default:   state_d = S_TRAP;  // TRAP is absorbing; unused codes fall into it
    endcase

    if (timeout_hit) begin
      state_d   = S_TRAP;
      mem_err_d = 1'b1;
    end
  end

  // ---------------------------------------------------------- timeout counter
  assign entering_wait = (state_d != state_q) &&
                         ((state_d == S_FETCH) || (state_d == S_MEM_RD) || (state_d == S_MEM_WR));

  always_comb begin
    cnt_d = cnt_q;
    if (entering_wait) begin
      cnt_d = '0;
    end else if (waiting && !mem_ready_i && !cnt_at_limit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // ------------------------------------------------------------------ state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
    end
  end

  // ---------------------------------------------------------- output decode
  logic                mem_req, mem_we, adr_src, ir_we, pc_we;
  logic [1:0]          alu_src_a, alu_src_b, result_src;
  logic [ALU_OP_W-1:0] alu_op;
  logic                reg_write, branch, retire;

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = '0;
    result_src = 2'b00;
    reg_write  = 1'b0;
    branch     = 1'b0;
    retire     = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_we      = mem_ready_i;
        pc_we      = mem_ready_i;  // PC <= PC+4 as the instruction lands
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEM_ADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEM_WB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        retire  = mem_ready_i;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = ALU_OP_W'(2'b10);
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = ALU_OP_W'(2'b11);
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = ALU_OP_W'(2'b01);
        branch    = 1'b1;
        retire    = 1'b1;
      end
`ifdef CTRL_JUMP_EN
      S_JAL: begin
        // PC <= branch target from DECODE; ALU-out <= oldPC+4 for the link write.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_we     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // The FSM resets to FETCH, which would otherwise request memory while
  // reset is still held, so the strobes are qualified by rst_ni directly.
  assign mem_req_o    = mem_req   & rst_ni;
  assign mem_we_o     = mem_we    & rst_ni;
  assign ir_we_o      = ir_we     & rst_ni;
  assign pc_we_o      = pc_we     & rst_ni;
  assign reg_write_o  = reg_write & rst_ni;
  assign branch_o     = branch    & rst_ni;
  assign retire_o     = retire    & rst_ni;
  assign adr_src_o    = adr_src;
  assign alu_src_a_o  = alu_src_a;
  assign alu_src_b_o  = alu_src_b;
  assign alu_op_o     = alu_op;
  assign result_src_o = result_src;
  assign illegal_o    = illegal_q;
  assign mem_err_o    = mem_err_q;
  assign state_o      = STATE_W'(state_q);

endmodule
`default_nettype wire
